// File: rtl/mem_pkg.sv
// Shared types and constants for the cache-fill memory responder.
// Each return-pipeline stage carries a {valid, data} pair.
package mem_pkg;

    localparam int MEM_LATENCY     = 4;
    localparam int MEM_LATENCY_MAX = 8;
    localparam int WORD_W          = 16;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
    } mem_ret_t;

endpackage

// File: rtl/mem_ret_pipe.sv
// Fixed-depth read-return delay line with no stall.
// Only the valid bits are cleared by reset; the data bits are don't-care while invalid.
module mem_ret_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic     clk,
    input  logic     rst,
    input  mem_ret_t i_push,
    output mem_ret_t o_tail
);

    logic [LATENCY-1:0] r_valid;
    logic [WORD_W-1:0]  r_data [LATENCY];

    if (LATENCY < 1 || LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
        $error("mem_ret_pipe: LATENCY must be in 1..8");
    end

    // Clearing the valid bits drops every in-flight read so it never returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= i_push.valid;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_data[0] <= i_push.data;
        for (int i = 1; i < LATENCY; i++) begin
            r_data[i] <= r_data[i-1];
        end
    end

    assign o_tail.valid = r_valid[LATENCY-1];
    assign o_tail.data  = r_data[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Single-port word storage answering arbiter requests: writes commit on the issuing
// edge, reads are captured at issue and returned LATENCY cycles later.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY,
    parameter int AW      = 16,
    parameter int DW      = WORD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          data_valid
);

    localparam int DEPTH = 1 << (AW - 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-2:0] w_idx;
    logic          w_wr_en;
    logic          w_rd_en;
    mem_ret_t      w_push;
    mem_ret_t      w_tail;

    // addr[0] selects a byte within the word and plays no part in storage.
    assign w_idx   = addr[AW-1:1];
    assign w_wr_en = enable & wr;
    assign w_rd_en = enable & ~wr;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= data_in;
        end
    end

    // Valid depends only on the strobes, so a floating addr while idle cannot
    // create a spurious return.
    always_comb begin
        w_push       = '0;
        w_push.valid = w_rd_en;
        if (w_rd_en) begin
            w_push.data = r_mem[w_idx];
        end
    end

    mem_ret_pipe #(
        .LATENCY (LATENCY)
    ) u_ret_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .o_tail (w_tail)
    );

    // Gating with valid gives data_out its zero reset value without resetting the data path.
    assign data_valid = w_tail.valid;
    assign data_out   = w_tail.valid ? w_tail.data : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: three responders (LATENCY 4, 1, 8) share one request stream;
// each has its own read pointer into a common expected-return list.
module tb_mem_responder;
    import mem_pkg::*;

    typedef struct {
        logic [15:0] data;
        int          issue;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] do4, do1, do8;
    logic        dv4, dv1, dv8;

    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    int   ptr [3];
    exp_t sb [$];

    mem_responder #(.LATENCY(4), .AW(16), .DW(16)) u_dut4 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(do4), .data_valid(dv4));
    mem_responder #(.LATENCY(1), .AW(16), .DW(16)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(do1), .data_valid(dv1));
    mem_responder #(.LATENCY(8), .AW(16), .DW(16)) u_dut8 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(do8), .data_valid(dv8));

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 8;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // A read issued at edge T must be visible after edge T+LATENCY-1.
    task automatic mon(input int k, input logic dv, input logic [15:0] dout);
        int   lat;
        exp_t e;
        lat = lat_of(k);
        if (dv) begin
            checks++;
            if (ptr[k] >= sb.size()) begin
                failures++;
                $display("FAIL unexpected_valid lat=%0d: got strobe data %h at edge %0d, expected none",
                         lat, dout, edge_cnt);
            end else begin
                e = sb[ptr[k]];
                ptr[k]++;
                if (dout !== e.data || edge_cnt != e.issue + lat - 1) begin
                    failures++;
                    $display("FAIL %s lat=%0d: got data %h at edge %0d, expected %h at edge %0d",
                             e.name, lat, dout, edge_cnt, e.data, e.issue + lat - 1);
                end
            end
        end else if (ptr[k] < sb.size() && sb[ptr[k]].issue + lat - 1 <= edge_cnt) begin
            checks++;
            failures++;
            $display("FAIL %s lat=%0d: got no strobe by edge %0d, expected data %h",
                     sb[ptr[k]].name, lat, edge_cnt, sb[ptr[k]].data);
            ptr[k]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0, dv4, do4);
        mon(1, dv1, do1);
        mon(2, dv8, do8);
    end

    task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
        exp_t e;
        e.data  = exp;
        e.issue = edge_cnt + 1;
        e.name  = name;
        sb.push_back(e);
        drive(1'b1, 1'b0, a, 16'h0000);
    endtask

    task automatic wrt(input logic [15:0] a, input logic [15:0] d);
        drive(1'b1, 1'b1, a, d);
    endtask

    // Idle cycles carry random wr/addr/data to show they have no effect.
    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; enable = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
        for (int k = 0; k < 3; k++) ptr[k] = 0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({dv4, dv1, dv8, do4, do1, do8}), 64'h0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("idle_after_reset", 64'({dv4, dv1, dv8, do4, do1, do8}), 64'h0);
        end

        // Write then read the same word through the odd byte address
        wrt(16'h0010, 16'hBEEF);
        rd("write_read", 16'h0011, 16'hBEEF);
        idle(10);

        // Streaming: preload words 0..7, then 8 back-to-back reads
        wrt(16'h0000, 16'h0000); wrt(16'h0002, 16'h1111);
        wrt(16'h0004, 16'h2222); wrt(16'h0006, 16'h3333);
        wrt(16'h0008, 16'h4444); wrt(16'h000A, 16'h5555);
        wrt(16'h000C, 16'h6666); wrt(16'h000E, 16'h7777);
        rd("stream0", 16'h0000, 16'h0000); rd("stream1", 16'h0002, 16'h1111);
        rd("stream2", 16'h0004, 16'h2222); rd("stream3", 16'h0006, 16'h3333);
        rd("stream4", 16'h0008, 16'h4444); rd("stream5", 16'h000A, 16'h5555);
        rd("stream6", 16'h000C, 16'h6666); rd("stream7", 16'h000E, 16'h7777);
        idle(10);

        // Read-then-write hazard, plus an idle cycle that must not write
        wrt(16'h0020, 16'h1234);
        idle(1);
        rd("hazard_old", 16'h0020, 16'h1234);
        wrt(16'h0020, 16'hAAAA);
        drive(1'b0, 1'b1, 16'h0020, 16'hDEAD);
        rd("hazard_new", 16'h0020, 16'hAAAA);
        idle(10);

        // Address wrap: 0xFFFE and 0xFFFF share the last word
        wrt(16'hFFFE, 16'h5A5A);
        rd("wrap_odd", 16'hFFFF, 16'h5A5A);
        wrt(16'hFFFF, 16'h0F0F);
        rd("wrap_even", 16'hFFFE, 16'h0F0F);
        idle(10);

        // Interleaved reads, writes and bubbles
        wrt(16'h0100, 16'hC001);
        rd("mix_a", 16'h0100, 16'hC001);
        idle(1);
        wrt(16'h0102, 16'hC002);
        rd("mix_b", 16'h0102, 16'hC002);
        rd("mix_c", 16'h0100, 16'hC001);
        wrt(16'h0100, 16'hC0FF);
        rd("mix_d", 16'h0101, 16'hC0FF);
        idle(2);
        rd("mix_e", 16'h0103, 16'hC002);
        idle(10);

        // Mid-flight reset: the LATENCY=1 responder has already returned the first two
        rd("flight0", 16'h0000, 16'h0000);
        rd("flight1", 16'h0002, 16'h1111);
        rd("flight2", 16'h0004, 16'h2222);
        enable = 1'b0;
        rst    = 1'b0;
        for (int k = 0; k < 3; k++) ptr[k] = sb.size();
        #1;
        chk("reset_drops_valid", 64'({dv4, dv1, dv8, do4, do1, do8}), 64'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", 64'({dv4, dv1, dv8}), 64'h0);
        end
        rst = 1'b1;
        rd("after_reset", 16'h0006, 16'h3333);
        idle(12);

        for (int k = 0; k < 3; k++) begin
            chk("all_returned", 64'(ptr[k]), 64'(sb.size()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the shared cache-fill bus driven by the memory interface arbiter. It accepts one request per cycle and writes commit on the issuing edge. Reads flow through a fixed-latency pipeline and return with a one-cycle `data_valid` strobe. It is the synthesizable, parameterized replacement for the behavioural multi-cycle main-memory model: the I-cache and D-cache miss FSMs on the other side of the arbiter see identical timing.

## Interface
- `LATENCY`, 4: cycles from read issue to `data_valid`; legal range 1..8.
- `AW`, 16: byte-address width on `addr`.
- `DW`, 16: data word width.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  request strobe; one request is accepted per cycle when high.
- `wr`  in  1  request type; 1 = write, 0 = read; ignored when `enable`=0.
- `addr`  in  AW  byte address; `addr[0]` is ignored, so the word index is `addr[AW-1:1]`.
- `data_in`  in  DW  write data; sampled only when `enable`&`wr`.
- `data_out`  out  DW  read data; defined only while `data_valid`=1.
- `data_valid`  out  1  single-cycle strobe marking returned read data.

## Operation
- Storage is 2^(AW-1) words of DW bits with a single port.
- Storage contents are not cleared by reset. Contents are undefined at power-up unless the bench preloads them.
- Write (`enable`=1, `wr`=1):
  - `mem[addr[AW-1:1]] <= data_in` on the same edge.
  - No `data_valid` is produced.
  - The next-cycle read of the same word returns the new value.
- Read (`enable`=1, `wr`=0):
  - The word is read on the issuing edge and pushed into stage 0 of the return pipeline together with valid=1.
  - Data is captured at issue. A write to the same word issued while the read is in flight does not alter the returned value.
- Return pipeline:
  - LATENCY stages, each holding a `{valid, data}` pair. It shifts every cycle.
  - No stall and no backpressure.
- Outputs: `data_valid` = valid of the last stage; `data_out` = data of the last stage.
- Requests are never rejected or reordered. N back-to-back reads produce N consecutive `data_valid` cycles, in issue order.
- Idle cycles (`enable`=0) insert bubbles (valid=0) into the pipeline.
- `enable`=0 with any `wr`/`addr`/`data_in` has no effect.
- X on `addr` while `enable`=0 must not propagate into storage or into pipeline valid bits.

## Timing
- Read issued at edge T: `data_valid`=1 and `data_out`=word during the cycle following edge T+LATENCY-1. For LATENCY=4 the strobe is seen 4 cycles after the cycle `enable` was high.
- Throughput is 1 request per cycle, any read/write mix.
- Reset asserted (`rst`=0):
  - All pipeline valid bits clear immediately (asynchronously), so `data_valid`=0 at once.
  - `data_out` resets to 0.
  - In-flight reads are dropped and are never returned.
- Reset deassertion: the first request is accepted on the first rising edge with `rst`=1.
- Write and read in consecutive cycles to the same word: the read returns the written data.
- Read then write to the same word in consecutive cycles: the read returns the old data.
- Address wrap: `addr` = 0xFFFE and 0xFFFF map to the same last word.

## Structure
- Shared package `mem_pkg` holds:
  - the `MEM_LATENCY` default (4) and `WORD_W` (16) constants;
  - typedef `mem_ret_t` = `{logic valid; logic [WORD_W-1:0] data}`, used per pipeline stage.
- Sub-module `mem_ret_pipe`:
  - a parameterized LATENCY-deep delay line of `mem_ret_t`;
  - async active-low clear of the valid bits only.
- The top-level holds the storage array and the decode of `enable`/`wr`.

## Test plan
- Reset then idle: `rst`=0 for 3 cycles, release, `enable`=0 for 10 cycles -> `data_valid` stays 0 throughout and `data_out`=0x0000.
- Write/read: write 0xBEEF to 0x0010, then read 0x0011 in the next cycle -> exactly one `data_valid` pulse, 4 cycles after the read, with `data_out`=0xBEEF.
- Streaming: preload words 0..7 with value index*0x1111; issue 8 back-to-back reads of addresses 0,2,..,14 -> 8 consecutive `data_valid` cycles returning 0x0000, 0x1111, .., 0x7777 in order.
- Read-then-write hazard: word 0x20 holds 0x1234; read 0x20 at cycle T, write 0xAAAA to 0x20 at T+1 -> returned data is 0x1234; a later read returns 0xAAAA.
- Mid-flight reset: issue 3 reads, assert `rst`=0 two cycles later -> `data_valid` drops immediately and no return ever appears for those reads; reads issued after release return normally.
- Parameter sweep: LATENCY=1 and LATENCY=8 with interleaved reads/writes/bubbles -> each read's `data_valid` arrives exactly LATENCY cycles after issue, checked by a scoreboard.
